regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated write scoreboard, the next-generation architectural register store for the CPU datapath. It supports a configurable number of combinational read ports with write-through bypass, an optional hard-wired zero register, and synchronous clear of all state. Per-register busy bits let the issue stage stall on read-after-write hazards while a result is in flight.

---
 rtl/rf_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned RF_BUS_WIDTH = 8;
  localparam int unsigned RF_DEPTH     = 8;
  localparam int unsigned RF_RD_PORTS  = 2;
  localparam int unsigned ZERO_ADDR    = 0;

  // Net change of the busy population for one cycle: +1, 0 or -1.
  function automatic logic signed [1:0] busy_delta(input logic inc, input logic dec);
    logic signed [1:0] d;
    d = 2'sd0;
    if (inc && !dec) d = 2'sd1;
    if (dec && !inc) d = -2'sd1;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with reserve/write priority and a running busy count.
module reg_scoreboard import rf_pkg::*; #(
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic [CW-1:0]    busy_count,
  output logic             all_idle
);

  logic             wr_ok;
  logic             rsv_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    count_nxt;
  logic signed [1:0] delta;

  // Next busy vector; a reservation overrides a same-address completing write.
  always_comb begin
    wr_ok     = we  && (32'(wr_addr)  < DEPTH) && !(ZERO_REG && (32'(wr_addr)  == ZERO_ADDR));
    rsv_ok    = rsv && (32'(rsv_addr) < DEPTH) && !(ZERO_REG && (32'(rsv_addr) == ZERO_ADDR));
    busy_nxt  = busy;
    inc       = 1'b0;
    dec       = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (wr_ok && (32'(wr_addr) == r)) begin
        busy_nxt[r] = 1'b0;
        dec         = busy[r];
      end
      if (rsv_ok && (32'(rsv_addr) == r)) begin
        busy_nxt[r] = 1'b1;
        inc         = !busy[r];
      end
    end
    if (wr_ok && rsv_ok && (wr_addr == rsv_addr)) dec = 1'b0;
    delta     = busy_delta(inc, dec);
    count_nxt = busy_count;
    if (delta > 2'sd0) count_nxt = busy_count + CW'(1);
    else if (delta < 2'sd0) count_nxt = busy_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
      all_idle   <= 1'b1;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
      all_idle   <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and an issue scoreboard.
module regfile_sb import rf_pkg::*; #(
  parameter int unsigned BUS_WIDTH = RF_BUS_WIDTH,
  parameter int unsigned DEPTH     = RF_DEPTH,
  parameter int unsigned RD_PORTS  = RF_RD_PORTS,
  parameter bit          ZERO_REG  = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [BUS_WIDTH-1:0]          wr_data,
  input  logic                          rsv,
  input  logic [AW-1:0]                 rsv_addr,
  input  logic [RD_PORTS*AW-1:0]        rd_addr,
  output logic [RD_PORTS*BUS_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]           rd_busy,
  output logic [AW:0]                   busy_count,
  output logic                          all_idle
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     busy;

  // Storage array; register 0 stays at zero when hard-wired.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (we && (32'(wr_addr) == r) && !(ZERO_REG && (r == ZERO_ADDR))) mem[r] <= wr_data;
      end
    end
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wr_addr    (wr_addr),
    .rsv        (rsv),
    .rsv_addr   (rsv_addr),
    .busy       (busy),
    .busy_count (busy_count),
    .all_idle   (all_idle)
  );

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0]        addr;
    logic                 ok;
    logic                 hit;
    logic [BUS_WIDTH-1:0] data;
    logic                 bsy;

    assign addr = rd_addr[i*AW +: AW];

    // Out-of-range and hard-wired zero addresses read as idle zero.
    always_comb begin
      ok   = (32'(addr) < DEPTH) && !(ZERO_REG && (32'(addr) == ZERO_ADDR));
      hit  = we && (wr_addr == addr);
      data = '0;
      bsy  = 1'b0;
      if (ok) begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
          if (32'(addr) == r) begin
            data = hit ? wr_data : mem[r];
            bsy  = busy[r] && !hit;
          end
        end
      end
    end

    assign rd_data[i*BUS_WIDTH +: BUS_WIDTH] = data;
    assign rd_busy[i]                        = bsy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised scoreboard bench for regfile_sb (6 registers, 4 read ports, zero register).
module tb_regfile_sb;

  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned RP    = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = AW + 1;
  localparam bit          Z     = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [BW-1:0]    wr_data;
  logic             rsv;
  logic [AW-1:0]    rsv_addr;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*BW-1:0] rd_data;
  logic [RP-1:0]    rd_busy;
  logic [AW:0]      busy_count;
  logic             all_idle;

  regfile_sb #(
    .BUS_WIDTH (BW),
    .DEPTH     (DEPTH),
    .RD_PORTS  (RP),
    .ZERO_REG  (Z)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv        (rsv),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .busy_count (busy_count),
    .all_idle   (all_idle)
  );

  typedef struct packed {
    logic [RP*BW-1:0] data;
    logic [RP-1:0]    busy;
    logic [CW-1:0]    cnt;
    logic             idle;
  } exp_t;

  exp_t          q[$];
  int            tests = 0;
  int            fails = 0;
  logic [BW-1:0] mdata [DEPTH];
  bit            mbusy [DEPTH];

  function automatic bit addr_ok(input int a);
    return (a < int'(DEPTH)) && !(Z && a == 0);
  endfunction

  // Reference: apply the clock edge that just happened using the inputs still held.
  function automatic void step_model();
    if (!rst_n) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        mdata[r] = '0;
        mbusy[r] = 1'b0;
      end
    end else begin
      if (we && addr_ok(int'(wr_addr))) begin
        mdata[int'(wr_addr)] = wr_data;
        mbusy[int'(wr_addr)] = 1'b0;
      end
      if (rsv && addr_ok(int'(rsv_addr))) mbusy[int'(rsv_addr)] = 1'b1;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   cnt;
    cnt = 0;
    e   = '0;
    for (int i = 0; i < int'(RP); i++) begin
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      if (addr_ok(a)) begin
        if (we && int'(wr_addr) == a) begin
          e.data[i*BW +: BW] = wr_data;
        end else begin
          e.data[i*BW +: BW] = mdata[a];
          e.busy[i]          = mbusy[a];
        end
      end
    end
    for (int r = 0; r < int'(DEPTH); r++) cnt += int'(mbusy[r]);
    e.cnt  = CW'(cnt);
    e.idle = (cnt == 0);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit w, input int wa, input logic [BW-1:0] wd,
                     input bit rv, input int ra, input int a0, input int a1, input int a2, input int a3);
    @(posedge clk);
    step_model();
    #1;
    rst_n    = r;
    we       = w;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv      = rv;
    rsv_addr = AW'(ra);
    rd_addr  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    q.push_back(predict());
  endtask

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data",    64'(rd_data),    64'(e.data));
        chk("rd_busy",    64'(rd_busy),    64'(e.busy));
        chk("busy_count", 64'(busy_count), 64'(e.cnt));
        chk("all_idle",   64'(all_idle),   64'(e.idle));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv      = 1'b0;
    rsv_addr = '0;
    rd_addr  = '0;

    cyc(0, 0, 0, 8'h00, 0, 0, 0, 1, 2, 3);
    // Reset: fill registers, reserve 3, then reset while a write/reserve is requested
    for (int k = 1; k <= 5; k++) cyc(1, 1, k, 8'hA5, 0, 0, 1, 2, 3, 4);
    cyc(1, 0, 0, 8'h00, 1, 3, 1, 2, 3, 5);
    cyc(0, 1, 2, 8'h77, 1, 4, 1, 2, 3, 4);
    cyc(1, 0, 0, 8'h00, 0, 0, 1, 2, 3, 4);
    cyc(1, 0, 0, 8'h00, 0, 0, 5, 2, 3, 4);
    // Bypass
    cyc(1, 1, 5, 8'h3C, 0, 0, 5, 1, 2, 3);
    cyc(1, 0, 0, 8'h00, 0, 0, 5, 1, 2, 3);
    // Zero register
    cyc(1, 1, 0, 8'hFF, 1, 0, 0, 0, 5, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0, 5, 0);
    // Scoreboard set/clear
    cyc(1, 0, 0, 8'h00, 1, 2, 2, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 2, 0, 0, 0);
    cyc(1, 1, 2, 8'h11, 0, 0, 2, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 2, 0, 0, 0);
    // Collision and concurrent different-address updates
    cyc(1, 0, 0, 8'h00, 1, 4, 4, 0, 0, 0);
    cyc(1, 1, 4, 8'h55, 1, 4, 4, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 4, 0, 0, 0);
    cyc(1, 1, 4, 8'h66, 1, 5, 4, 5, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 4, 5, 0, 0);
    // Multi-port reads and out-of-range addresses
    for (int k = 1; k <= 4; k++) cyc(1, 1, k, BW'(k), 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0, 1, 2, 3, 4);
    cyc(1, 1, 7, 8'hEE, 1, 6, 7, 6, 0, 5);
    cyc(1, 0, 0, 8'h00, 0, 0, 7, 6, 5, 1);

    for (int n = 0; n < 3000; n++) begin
      int wa;
      int a0;
      wa = int'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
      cyc(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), wa, BW'($urandom),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          a0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
